// File: rtl/io_spart_responder.sv
// ============================================================================
// io_spart_responder: memory-mapped IO slave in front of a SPART UART, with
// TX launch, RX FIFO, status/overflow and baud divisor register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_spart_responder #(
   parameter int          RX_DEPTH    = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] io_addr,
   input  logic [31:0] io_wr_data,
   input  logic        io_rw,
   input  logic        io_valid,
   output logic [31:0] io_rd_data,
   output logic        io_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_strobe,
   output logic [15:0] baud_div
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] REG_TX   = 2'b00;
   localparam logic [1:0] REG_RX   = 2'b01;
   localparam logic [1:0] REG_STAT = 2'b10;
   localparam logic [1:0] REG_DIV  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECODE  = 3'd1,
      S_TX_WAIT = 3'd2,
      S_RESP    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      addr_q, addr_d;
   logic            rw_q, rw_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            ready_q, ready_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [15:0]     baud_q, baud_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [RX_DEPTH];

   logic            full, nonempty, tx_ready, pop, push;
   logic [4:0]      count_ext;
   logic [2:0]      cnt_field;
   logic [31:0]     status;
   logic            unused_bits;

   assign unused_bits = ^{io_addr[27:4], io_addr[1:0], io_wr_data[31:16]};

   assign full      = (count_q == CW'(RX_DEPTH));
   assign nonempty  = (count_q != '0);
   assign count_ext = 5'(count_q);
   assign cnt_field = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
   // A launch is pending while stalled in TX_WAIT or while tx_start is still out.
   assign tx_ready  = ~tx_busy & ~tx_start_q & (state_q != S_TX_WAIT);
   assign status    = {25'b0, cnt_field, ovf_q, full, tx_ready, nonempty};

   assign pop  = (state_q == S_DECODE) && (addr_q == REG_RX) && !rw_q && nonempty;
   assign push = rx_strobe && (!full || pop);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      wdata_d    = wdata_q;
      ready_d    = 1'b0;
      rd_data_d  = 32'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      baud_d     = baud_q;
      ovf_d      = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (io_valid) begin
               addr_d  = io_addr[3:2];
               rw_d    = io_rw;
               wdata_d = io_wr_data[15:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (rw_q && (addr_q == REG_TX) && tx_busy) begin
               state_d = S_TX_WAIT;
            end else begin
               state_d = S_RESP;
               ready_d = 1'b1;
               case (addr_q)
                  REG_TX: begin
                     if (rw_q) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = wdata_q[7:0];
                     end
                  end
                  REG_RX: begin
                     if (!rw_q && nonempty) rd_data_d = {24'b0, mem_q[head_q]};
                  end
                  REG_STAT: begin
                     if (rw_q) begin
                        if (wdata_q[3]) ovf_d = 1'b0;
                     end else begin
                        rd_data_d = status;
                     end
                  end
                  default: begin
                     if (rw_q) baud_d = wdata_q;
                     else      rd_data_d = {16'b0, baud_q};
                  end
               endcase
            end
         end
         S_TX_WAIT: begin
            if (!tx_busy) begin
               state_d    = S_RESP;
               ready_d    = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = wdata_q[7:0];
            end
         end
         S_RESP:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A dropped byte re-flags overflow even if software clears it this cycle.
      if (rx_strobe && full && !pop) ovf_d = 1'b1;
   end

   always_comb begin
      head_d  = pop  ? head_q + PW'(1) : head_q;
      tail_d  = push ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= 2'b0;
         rw_q       <= 1'b0;
         wdata_q    <= 16'b0;
         ready_q    <= 1'b0;
         rd_data_q  <= 32'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'b0;
         baud_q     <= DEFAULT_DIV;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         wdata_q    <= wdata_d;
         ready_q    <= ready_d;
         rd_data_q  <= rd_data_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         baud_q     <= baud_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= rx_data;
   end

   assign io_ready   = ready_q;
   assign io_rd_data = rd_data_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign baud_div   = baud_q;

endmodule

`default_nettype wire

// File: tb/tb_io_spart_responder.sv
// ============================================================================
// tb_io_spart_responder: directed self-checking bench for io_spart_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_spart_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [27:0] io_addr;
   logic [31:0] io_wr_data;
   logic        io_rw;
   logic        io_valid;
   logic [31:0] io_rd_data;
   logic        io_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_strobe;
   logic [15:0] baud_div;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [27:0] A_TX   = 28'h0000000;
   localparam logic [27:0] A_RX   = 28'h0000004;
   localparam logic [27:0] A_STAT = 28'h0000008;
   localparam logic [27:0] A_DIV  = 28'h000000C;

   io_spart_responder #(.RX_DEPTH(4), .DEFAULT_DIV(16'd162)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_addr    (io_addr),
      .io_wr_data (io_wr_data),
      .io_rw      (io_rw),
      .io_valid   (io_valid),
      .io_rd_data (io_rd_data),
      .io_ready   (io_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .rx_data    (rx_data),
      .rx_strobe  (rx_strobe),
      .baud_div   (baud_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic access(input logic rw, input logic [27:0] addr, input logic [31:0] wd,
                         input logic hold, output logic [31:0] rd, output int lat,
                         output int starts, output int extra);
      io_addr = addr; io_rw = rw; io_wr_data = wd; io_valid = 1'b1;
      rd = '0; lat = -1; starts = 0; extra = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (tx_start) starts++;
         if (io_ready) begin
            rd  = io_rd_data;
            lat = i;
            break;
         end
      end
      if (!hold) io_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 1) io_valid = 1'b0;
         if (io_ready) extra++;
         if (tx_start) starts++;
      end
      io_valid = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data = b; rx_strobe = 1'b1;
      @(posedge clk); #1;
      rx_strobe = 1'b0;
   endtask

   logic [31:0] rd;
   int lat, starts, extra;

   initial begin
      rst_n = 1'b0; io_addr = '0; io_wr_data = '0; io_rw = 1'b0; io_valid = 1'b0;
      tx_busy = 1'b0; rx_data = '0; rx_strobe = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      check("rst_io_ready", 32'(io_ready), 32'd0);
      check("rst_rd_data", io_rd_data, 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_baud", 32'(baud_div), 32'd162);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rst_status", rd, 32'h02);
      check("rst_status_lat", 32'(lat), 32'd2);

      // Unstalled transmit
      access(1'b1, A_TX, 32'h41, 1'b0, rd, lat, starts, extra);
      check("tx41_lat", 32'(lat), 32'd2);
      check("tx41_starts", 32'(starts), 32'd1);
      check("tx41_data", 32'(tx_data), 32'h41);
      check("tx41_rd_zero", rd, 32'd0);
      check("tx41_extra", 32'(extra), 32'd0);

      // Transmitter busy for 10 cycles: ready and launch only after it falls
      tx_busy = 1'b1;
      fork
         begin
            repeat (10) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      join_none
      access(1'b1, A_TX, 32'h55, 1'b0, rd, lat, starts, extra);
      check("tx55_lat", 32'(lat), 32'd11);
      check("tx55_starts", 32'(starts), 32'd1);
      check("tx55_data", 32'(tx_data), 32'h55);

      // Overflow: five bytes into a four-deep FIFO
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("ovf_status", rd, 32'h4F);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rx_pop0", rd, 32'h11);
      check("rx_pop0_lat", 32'(lat), 32'd2);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rx_pop1", rd, 32'h22);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rx_pop2", rd, 32'h33);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rx_pop3", rd, 32'h44);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("rx_empty", rd, 32'h0);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("empty_ovf_status", rd, 32'h0A);
      access(1'b1, A_STAT, 32'h8, 1'b0, rd, lat, starts, extra);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("ovf_cleared", rd, 32'h02);

      // Push lands on the same edge as a pop of a full FIFO
      push_byte(8'h66); push_byte(8'h77); push_byte(8'h88); push_byte(8'h99);
      fork
         begin
            @(posedge clk);
            #1 rx_data = 8'hAA; rx_strobe = 1'b1;
            @(posedge clk);
            #1 rx_strobe = 1'b0;
         end
      join_none
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_pop", rd, 32'h66);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_status", rd, 32'h47);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_pop1", rd, 32'h77);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_pop2", rd, 32'h88);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_pop3", rd, 32'h99);
      access(1'b0, A_RX, 32'd0, 1'b0, rd, lat, starts, extra);
      check("simul_kept", rd, 32'hAA);

      // io_valid held through the cycle after io_ready: only one pop
      push_byte(8'hB1); push_byte(8'hB2);
      access(1'b0, A_RX, 32'd0, 1'b1, rd, lat, starts, extra);
      check("hold_rd", rd, 32'hB1);
      check("hold_extra_ready", 32'(extra), 32'd0);
      check("hold_rd_idle_zero", io_rd_data, 32'd0);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("hold_status", rd, 32'h13);

      // Divisor write/read, including an aliased upper address
      access(1'b1, A_DIV, 32'hFFFF0036, 1'b0, rd, lat, starts, extra);
      check("div_out", 32'(baud_div), 32'h36);
      access(1'b0, 28'hABCDEFC, 32'd0, 1'b0, rd, lat, starts, extra);
      check("div_read", rd, 32'h36);

      // Reset while stalled in TX_WAIT: abandon without ready or launch
      io_addr = A_TX; io_rw = 1'b1; io_wr_data = 32'h77; tx_busy = 1'b1; io_valid = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_baud", 32'(baud_div), 32'd162);
      check("rst_mid_ready", 32'(io_ready), 32'd0);
      check("rst_mid_start", 32'(tx_start), 32'd0);
      io_valid = 1'b0; tx_busy = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      extra = 0; starts = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (io_ready) extra++;
         if (tx_start) starts++;
      end
      check("post_rst_ready", 32'(extra), 32'd0);
      check("post_rst_start", 32'(starts), 32'd0);
      check("post_rst_tx_data", 32'(tx_data), 32'd0);
      access(1'b0, A_STAT, 32'd0, 1'b0, rd, lat, starts, extra);
      check("post_rst_status", rd, 32'h02);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
